deserializer_align: RTL and testbench

DESERIALIZER_ALIGN -- requirements
Module: deserializer_align

---
 rtl/deser_pkg.sv | 13 +
 rtl/deserializer_align_comma_detect.sv | 14 +
 rtl/deserializer_align.sv | 130 +++++++++++++
 tb/tb_deserializer_align.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/deser_pkg.sv
// Shared types and constants for the serial word aligner.
// Holds the aligner FSM state encoding and the default alignment character.
package deser_pkg;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } deser_state_e;

  localparam logic [7:0] DEFAULT_COMMA = 8'hBC;

endpackage

// File: rtl/deserializer_align_comma_detect.sv
// Alignment-character comparator: flags when the candidate word equals COMMA.
module comma_detect
  import deser_pkg::*;
#(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] COMMA = WIDTH'(DEFAULT_COMMA)
) (
  input  logic [WIDTH-1:0] word,
  output logic             match
);

  assign match = (word == COMMA);

endmodule

// File: rtl/deserializer_align.sv
// Serial-to-parallel converter with comma-based word alignment (HUNT/VERIFY/LOCKED).
// Optional build macro DESER_COMMA_STRIP_EN suppresses delivery of aligned commas once locked.
module deserializer_align
  import deser_pkg::*;
#(
  parameter int               WIDTH      = 8,
  parameter logic [WIDTH-1:0] COMMA      = WIDTH'(DEFAULT_COMMA),
  parameter int               LOCK_COUNT = 4
) (
  input  logic             clk_32f,
  input  logic             reset,
  input  logic             data_in,
  input  logic             resync,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  output logic             active,
  output logic [3:0]       bc_counter
);

  localparam int               CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [3:0]       LOCK_VAL = 4'(LOCK_COUNT);

  deser_state_e     state;
  deser_state_e     state_next;
  logic [WIDTH-2:0] sr;
  logic [CNT_W-1:0] bit_cnt;
  logic [CNT_W-1:0] bit_cnt_next;
  logic [WIDTH-1:0] word;
  logic [WIDTH-1:0] data_out_next;
  logic             data_valid_next;
  logic [3:0]       bc_next;
  logic             is_comma;
  logic             boundary;

  // The newest bit is part of the candidate word, so a match is seen in the same cycle it arrives.
  assign word     = {sr, data_in};
  assign boundary = (bit_cnt == LAST_BIT);

  comma_detect #(
    .WIDTH(WIDTH),
    .COMMA(COMMA)
  ) u_comma_detect (
    .word (word),
    .match(is_comma)
  );

  always_comb begin
    state_next      = state;
    bc_next         = bc_counter;
    data_out_next   = data_out;
    data_valid_next = 1'b0;
    bit_cnt_next    = boundary ? '0 : bit_cnt + CNT_ONE;

    // Resync wins over any boundary or comma seen in the same cycle.
    if (resync) begin
      state_next = HUNT;
      bc_next    = '0;
    end else begin
      case (state)
        HUNT: begin
          if (is_comma) begin
            bit_cnt_next = '0;
            bc_next      = 4'd1;
            state_next   = (LOCK_COUNT == 1) ? LOCKED : VERIFY;
          end
        end

        VERIFY: begin
          if (boundary) begin
            if (is_comma) begin
              bc_next = bc_counter + 4'd1;
              if (bc_counter + 4'd1 == LOCK_VAL) begin
                state_next = LOCKED;
              end
            end else begin
              bc_next    = '0;
              state_next = HUNT;
            end
          end
        end

        LOCKED: begin
          if (boundary) begin
            if (is_comma) begin
              bc_next = LOCK_VAL;
            end
`ifdef DESER_COMMA_STRIP_EN
            if (!is_comma) begin
              data_out_next   = word;
              data_valid_next = 1'b1;
            end
`else
            data_out_next   = word;
            data_valid_next = 1'b1;
`endif
          end
        end

        default: begin
          state_next = HUNT;
          bc_next    = '0;
        end
      endcase
    end
  end

  // active tracks the state being entered so it changes on the same edge as the state.
  always_ff @(posedge clk_32f) begin
    if (reset) begin
      state      <= HUNT;
      sr         <= '0;
      bit_cnt    <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      active     <= 1'b0;
      bc_counter <= '0;
    end else begin
      state      <= state_next;
      sr         <= word[WIDTH-2:0];
      bit_cnt    <= bit_cnt_next;
      data_out   <= data_out_next;
      data_valid <= data_valid_next;
      active     <= (state_next == LOCKED);
      bc_counter <= bc_next;
    end
  end

endmodule

// File: tb/tb_deserializer_align.sv
// Scoreboard bench for deserializer_align: an 8-bit instance and a 10-bit (COMMA 10'h17C) instance.
module tb_deserializer_align;

  logic clk_32f = 1'b0;
  always #5 clk_32f = ~clk_32f;

  logic       reset_a  = 1'b1;
  logic       resync_a = 1'b0;
  logic       din_a    = 1'b0;
  logic [7:0] dout_a;
  logic       dv_a;
  logic       act_a;
  logic [3:0] bc_a;

  logic       reset_b  = 1'b1;
  logic       resync_b = 1'b0;
  logic       din_b    = 1'b0;
  logic [9:0] dout_b;
  logic       dv_b;
  logic       act_b;
  logic [3:0] bc_b;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_q_a[$];
  logic [9:0] exp_q_b[$];
  logic [7:0] exp_word_a;
  logic [9:0] exp_word_b;

  deserializer_align #(
    .WIDTH(8), .COMMA(8'hBC), .LOCK_COUNT(4)
  ) dut_a (
    .clk_32f   (clk_32f),
    .reset     (reset_a),
    .data_in   (din_a),
    .resync    (resync_a),
    .data_out  (dout_a),
    .data_valid(dv_a),
    .active    (act_a),
    .bc_counter(bc_a)
  );

  deserializer_align #(
    .WIDTH(10), .COMMA(10'h17C), .LOCK_COUNT(4)
  ) dut_b (
    .clk_32f   (clk_32f),
    .reset     (reset_b),
    .data_in   (din_b),
    .resync    (resync_b),
    .data_out  (dout_b),
    .data_valid(dv_b),
    .active    (act_b),
    .bc_counter(bc_b)
  );

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // One serial bit into the selected instance; returns #1 after the sampling edge.
  task automatic send_bit(input bit sel_b, input logic b, input logic rs);
    if (sel_b) begin
      din_b    = b;
      resync_b = rs;
    end else begin
      din_a    = b;
      resync_a = rs;
    end
    @(posedge clk_32f);
    #1;
    din_a    = 1'b0;
    din_b    = 1'b0;
    resync_a = 1'b0;
    resync_b = 1'b0;
  endtask

  task automatic apply_stimulus(input bit sel_b, input logic [9:0] w, input int width, input bit rs_last);
    for (int i = width - 1; i >= 0; i--) begin
      send_bit(sel_b, w[i], rs_last && (i == 0));
    end
  endtask

  task automatic pulse_reset_a();
    reset_a = 1'b1;
    @(posedge clk_32f);
    #1;
    reset_a = 1'b0;
  endtask

  task automatic lock_a();
    for (int k = 1; k <= 4; k++) begin
      apply_stimulus(1'b0, 10'h0BC, 8, 1'b0);
    end
    check_output("lock_a_active", {31'd0, act_a}, 32'd1);
  endtask

  // Monitor: every data_valid pulse must match the oldest queued expectation.
  initial begin
    forever begin
      @(negedge clk_32f);
      if (dv_a === 1'b1) begin
        if (exp_q_a.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_valid_a: got data_out %0h, expected no data_valid", dout_a);
        end else begin
          exp_word_a = exp_q_a.pop_front();
          check_output("data_out_a", {24'd0, dout_a}, {24'd0, exp_word_a});
        end
      end
      if (dv_b === 1'b1) begin
        if (exp_q_b.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_valid_b: got data_out %0h, expected no data_valid", dout_b);
        end else begin
          exp_word_b = exp_q_b.pop_front();
          check_output("data_out_b", {22'd0, dout_b}, {22'd0, exp_word_b});
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected bench to finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    repeat (2) @(posedge clk_32f);
    #1;
    check_output("reset_dout_a", {24'd0, dout_a}, 32'd0);
    check_output("reset_dv_a",   {31'd0, dv_a},   32'd0);
    check_output("reset_act_a",  {31'd0, act_a},  32'd0);
    check_output("reset_bc_a",   {28'd0, bc_a},   32'd0);

    // Aligned commas from reset, then one data word.
    reset_a = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      apply_stimulus(1'b0, 10'h0BC, 8, 1'b0);
      check_output($sformatf("t1_bc_%0d", k), {28'd0, bc_a}, k);
      check_output($sformatf("t1_act_%0d", k), {31'd0, act_a}, (k == 4) ? 32'd1 : 32'd0);
    end
    exp_q_a.push_back(8'h5A);
    apply_stimulus(1'b0, 10'h05A, 8, 1'b0);
    check_output("t1_dv_pulse", {31'd0, dv_a}, 32'd1);
    send_bit(1'b0, 1'b0, 1'b0);
    check_output("t1_dv_one_cycle", {31'd0, dv_a}, 32'd0);
    check_output("t1_dout_hold", {24'd0, dout_a}, 32'h5A);

    // Misaligned stream: three junk bits ahead of the commas.
    pulse_reset_a();
    send_bit(1'b0, 1'b1, 1'b0);
    send_bit(1'b0, 1'b0, 1'b0);
    send_bit(1'b0, 1'b1, 1'b0);
    for (int k = 1; k <= 4; k++) begin
      apply_stimulus(1'b0, 10'h0BC, 8, 1'b0);
      check_output($sformatf("t2_bc_%0d", k), {28'd0, bc_a}, k);
    end
    check_output("t2_active", {31'd0, act_a}, 32'd1);
    exp_q_a.push_back(8'h11);
    apply_stimulus(1'b0, 10'h011, 8, 1'b0);

    // Broken verify run: comma, comma, junk, comma.
    pulse_reset_a();
    apply_stimulus(1'b0, 10'h0BC, 8, 1'b0);
    check_output("t3_bc_1", {28'd0, bc_a}, 32'd1);
    apply_stimulus(1'b0, 10'h0BC, 8, 1'b0);
    check_output("t3_bc_2", {28'd0, bc_a}, 32'd2);
    apply_stimulus(1'b0, 10'h000, 8, 1'b0);
    check_output("t3_bc_0", {28'd0, bc_a}, 32'd0);
    check_output("t3_act_0", {31'd0, act_a}, 32'd0);
    apply_stimulus(1'b0, 10'h0BC, 8, 1'b0);
    check_output("t3_bc_rehunt", {28'd0, bc_a}, 32'd1);
    check_output("t3_act_1", {31'd0, act_a}, 32'd0);

    // Resync coincident with a word boundary suppresses that word.
    pulse_reset_a();
    lock_a();
    apply_stimulus(1'b0, 10'h077, 8, 1'b1);
    check_output("t4_dv", {31'd0, dv_a}, 32'd0);
    check_output("t4_act", {31'd0, act_a}, 32'd0);
    check_output("t4_bc", {28'd0, bc_a}, 32'd0);
    apply_stimulus(1'b0, 10'h077, 8, 1'b0);
    check_output("t4_act_hunt", {31'd0, act_a}, 32'd0);

    // Comma followed by data while locked.
    pulse_reset_a();
    lock_a();
`ifndef DESER_COMMA_STRIP_EN
    exp_q_a.push_back(8'hBC);
`endif
    exp_q_a.push_back(8'h33);
    apply_stimulus(1'b0, 10'h0BC, 8, 1'b0);
    check_output("t5_bc_hold", {28'd0, bc_a}, 32'd4);
    apply_stimulus(1'b0, 10'h033, 8, 1'b0);
    check_output("t5_bc_data", {28'd0, bc_a}, 32'd4);
    check_output("t5_act", {31'd0, act_a}, 32'd1);
    reset_a = 1'b1;

    // 10-bit instance: lock, deliver, resync, then reset in the middle of VERIFY.
    check_output("t6_reset_bc", {28'd0, bc_b}, 32'd0);
    reset_b = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      apply_stimulus(1'b1, 10'h17C, 10, 1'b0);
    end
    check_output("t6_lock_act", {31'd0, act_b}, 32'd1);
    exp_q_b.push_back(10'h2A5);
    apply_stimulus(1'b1, 10'h2A5, 10, 1'b0);
    send_bit(1'b1, 1'b0, 1'b1);
    check_output("t6_resync_act", {31'd0, act_b}, 32'd0);
    apply_stimulus(1'b1, 10'h17C, 10, 1'b0);
    check_output("t6_verify_bc", {28'd0, bc_b}, 32'd1);
    send_bit(1'b1, 1'b0, 1'b0);
    send_bit(1'b1, 1'b1, 1'b0);
    send_bit(1'b1, 1'b0, 1'b0);
    send_bit(1'b1, 1'b1, 1'b0);
    reset_b = 1'b1;
    send_bit(1'b1, 1'b1, 1'b0);
    reset_b = 1'b0;
    check_output("t6_mid_dout", {22'd0, dout_b}, 32'd0);
    check_output("t6_mid_dv",   {31'd0, dv_b},   32'd0);
    check_output("t6_mid_act",  {31'd0, act_b},  32'd0);
    check_output("t6_mid_bc",   {28'd0, bc_b},   32'd0);
    for (int k = 1; k <= 4; k++) begin
      apply_stimulus(1'b1, 10'h17C, 10, 1'b0);
      check_output($sformatf("t6_relock_bc_%0d", k), {28'd0, bc_b}, k);
      check_output($sformatf("t6_relock_act_%0d", k), {31'd0, act_b}, (k == 4) ? 32'd1 : 32'd0);
    end
    exp_q_b.push_back(10'h0F0);
    apply_stimulus(1'b1, 10'h0F0, 10, 1'b0);
    reset_b = 1'b1;

    repeat (2) @(negedge clk_32f);
    check_output("pending_a", exp_q_a.size(), 32'd0);
    check_output("pending_b", exp_q_b.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
